// File: rtl/err_monitor_pkg.sv
// Shared types and constants for the pipeline error monitor.
// Stage indices follow pipeline order; a higher index holds an older instruction.
package err_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_STAGE       = 2'd1;
  localparam logic [1:0] ERR_HANG        = 2'd2;
  localparam logic [1:0] ERR_HALT_RETIRE = 2'd3;

  localparam logic [2:0] STG_IF         = 3'd0;
  localparam logic [2:0] STG_ID         = 3'd1;
  localparam logic [2:0] STG_EX         = 3'd2;
  localparam logic [2:0] STG_MEM        = 3'd3;
  localparam logic [2:0] STG_WB         = 3'd4;
  localparam logic [2:0] ERR_STAGE_NONE = 3'd7;

  // The oldest instruction (WB side) is reported when several stages fault together.
  function automatic logic [2:0] oldest_stage(input logic [4:0] qual);
    if (qual[4])      return STG_WB;
    else if (qual[3]) return STG_MEM;
    else if (qual[2]) return STG_EX;
    else if (qual[1]) return STG_ID;
    else if (qual[0]) return STG_IF;
    else              return ERR_STAGE_NONE;
  endfunction

endpackage

// File: rtl/err_wdog.sv
// Hang watchdog: down-counter reloaded on every kick, expiring on the
// LIMIT-th consecutive enabled cycle without a kick.
module err_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int         W      = $clog2(LIMIT);
  localparam logic [W-1:0] RELOAD = W'(LIMIT - 1);

  logic [W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (kick)
      rem_d = RELOAD;
    else if (en && (rem_q != '0))
      rem_d = rem_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rem_q <= RELOAD;
    else
      rem_q <= rem_d;
  end

  // Remaining count of zero means LIMIT-1 idle cycles already elapsed.
  assign expire = en & ~kick & (rem_q == '0);

endmodule

// File: rtl/err_monitor.sv
// Pipeline error monitor: latches the first stage error, hang or post-halt
// retire as a sticky fault, and tracks cycle/retire counts while running.
module err_monitor
  import err_monitor_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       stg_err,
  input  logic [4:0]       stg_vld,
  input  logic             retire,
  input  logic             halt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [2:0]       err_stage,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [2:0]       stage_q, stage_d;
  logic [CNT_W-1:0] cyc_q, ret_q;
  logic [4:0]       stg_qual;
  logic             in_run;
  logic             wdog_expire;

  assign stg_qual = stg_err & stg_vld;
  assign in_run   = (state_q == ST_RUN);

  err_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (in_run),
    .kick   (retire),
    .expire (wdog_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      code_q  <= ERR_NONE;
      stage_q <= ERR_STAGE_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      stage_q <= stage_d;
    end
  end

  // Counters only advance while running; they wrap silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (in_run) begin
      cyc_q <= cyc_q + 1'b1;
      if (retire)
        ret_q <= ret_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    stage_d = stage_q;
    case (state_q)
      ST_RUN: begin
        if (stg_qual != '0) begin
          state_d = ST_FAULT;
          code_d  = ERR_STAGE;
          stage_d = oldest_stage(stg_qual);
        end else if (wdog_expire) begin
          state_d = ST_FAULT;
          code_d  = ERR_HANG;
          stage_d = ERR_STAGE_NONE;
        end else if (retire && halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (retire) begin
          state_d = ST_FAULT;
          code_d  = ERR_HALT_RETIRE;
          stage_d = ERR_STAGE_NONE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    err        = (state_q == ST_FAULT);
    halted     = (state_q == ST_HALTED);
    err_code   = code_q;
    err_stage  = stage_q;
    cycle_cnt  = cyc_q;
    retire_cnt = ret_q;
  end

endmodule

// File: tb/tb_err_monitor.sv
// Directed bench for err_monitor with a per-cycle reference model feeding a
// scoreboard queue, plus targeted checks of each scenario's end state.
module tb_err_monitor;
  import err_monitor_pkg::*;

  localparam int LIMIT = 8;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    stg_err, stg_vld;
  logic          retire, halt;
  logic          err;
  logic [1:0]    err_code;
  logic [2:0]    err_stage;
  logic          halted;
  logic [CW-1:0] cycle_cnt, retire_cnt;

  always #5 clk = ~clk;

  err_monitor #(.WDOG_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stg_err    (stg_err),
    .stg_vld    (stg_vld),
    .retire     (retire),
    .halt       (halt),
    .err        (err),
    .err_code   (err_code),
    .err_stage  (err_stage),
    .halted     (halted),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  typedef struct packed {
    logic          e;
    logic [1:0]    c;
    logic [2:0]    s;
    logic          h;
    logic [CW-1:0] cy;
    logic [CW-1:0] rt;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: 0=run, 1=halted, 2=fault
  int            m_st;
  logic [1:0]    m_code;
  logic [2:0]    m_stage;
  logic [CW-1:0] m_cyc, m_ret;
  int            m_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model(input logic r, input logic [4:0] e, input logic [4:0] v,
                       input logic ret, input logic h);
    logic [4:0] q;
    obs_t       x;
    q = e & v;
    if (r) begin
      m_st = 0; m_code = 2'd0; m_stage = 3'd7; m_cyc = '0; m_ret = '0; m_idle = 0;
    end else if (m_st == 0) begin
      m_cyc++;
      if (ret) m_ret++;
      if (q != 5'd0) begin
        m_st = 2; m_code = 2'd1; m_stage = 3'd7;
        for (int i = 0; i < 5; i++) if (q[i]) m_stage = 3'(i);
      end else if (!ret && m_idle == LIMIT - 1) begin
        m_st = 2; m_code = 2'd2; m_stage = 3'd7;
      end else if (ret && h) begin
        m_st = 1;
      end
      m_idle = ret ? 0 : m_idle + 1;
    end else if (m_st == 1) begin
      if (ret) begin
        m_st = 2; m_code = 2'd3; m_stage = 3'd7;
      end
    end
    x = {(m_st == 2), m_code, m_stage, (m_st == 1), m_cyc, m_ret};
    exp_q.push_back(x);
  endtask

  task automatic step(input string tag, input logic r, input logic [4:0] e,
                      input logic [4:0] v, input logic ret, input logic h);
    obs_t o, x;
    rst = r; stg_err = e; stg_vld = v; retire = ret; halt = h;
    model(r, e, v, ret, h);
    @(posedge clk);
    #1;
    o = {err, err_code, err_stage, halted, cycle_cnt, retire_cnt};
    x = exp_q.pop_front();
    chk(tag, o, x);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step("reset", 1'b1, 5'h1f, 5'h1f, 1'b1, 1'b1);
  endtask

  task automatic run(input string tag, input int n, input logic ret);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd0, 5'd0, ret, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stg_err = '0; stg_vld = '0; retire = 1'b0; halt = 1'b0;
    @(posedge clk); #1;

    // Reset with all inputs active: they must be ignored.
    do_reset(2);
    chk("rst_err", err, 0);
    chk("rst_stage", err_stage, 7);
    chk("rst_code", err_code, 0);
    chk("rst_cyc", cycle_cnt, 0);

    run("retire50", 50, 1'b1);
    chk("r50_err", err, 0);
    chk("r50_ret", retire_cnt, 50);
    chk("r50_cyc", cycle_cnt, 50);

    // Counters wrap modulo 2^CW without faulting.
    run("wrap", 210, 1'b1);
    chk("wrap_cyc", cycle_cnt, 4);
    chk("wrap_ret", retire_cnt, 4);
    chk("wrap_err", err, 0);

    // Single EX error at cycle 10, then sticky for 100 cycles of noise.
    do_reset(2);
    run("pre_ex", 9, 1'b1);
    step("ex_err", 1'b0, 5'b00100, 5'b00100, 1'b1, 1'b0);
    chk("ex_err_o", err, 1);
    chk("ex_code", err_code, 1);
    chk("ex_stage", err_stage, 2);
    for (int i = 0; i < 100; i++)
      step("sticky", 1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
    chk("sticky_stage", err_stage, 2);
    chk("sticky_cyc", cycle_cnt, 10);

    // Unqualified error ignored; multiple errors report the oldest stage.
    do_reset(1);
    run("pre_multi", 3, 1'b1);
    step("unqual", 1'b0, 5'b00100, 5'b00000, 1'b1, 1'b0);
    chk("unqual_err", err, 0);
    step("multi", 1'b0, 5'b01010, 5'b11111, 1'b0, 1'b0);
    chk("multi_code", err_code, 1);
    chk("multi_stage", err_stage, 3);

    // Stage error beats a watchdog expiry in the same cycle.
    do_reset(1);
    run("pre_prio", 7, 1'b0);
    step("prio", 1'b0, 5'b00001, 5'b00001, 1'b0, 1'b0);
    chk("prio_code", err_code, 1);
    chk("prio_stage", err_stage, 0);

    // Watchdog expires on the 8th idle cycle after reset.
    do_reset(1);
    run("idle7", 7, 1'b0);
    chk("idle7_err", err, 0);
    run("idle8", 1, 1'b0);
    chk("wd_err", err, 1);
    chk("wd_code", err_code, 2);
    chk("wd_stage", err_stage, 7);

    // A retire at idle=7 restarts the count.
    do_reset(1);
    run("kick_a", 7, 1'b0);
    run("kick", 1, 1'b1);
    run("kick_b", 7, 1'b0);
    chk("kick_err", err, 0);
    run("kick_c", 1, 1'b0);
    chk("kick_wd", err_code, 2);

    // Halt at cycle 5, retire again at cycle 9.
    do_reset(2);
    step("halt_noret", 1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    chk("halt_noret", halted, 0);
    do_reset(1);
    run("pre_halt", 4, 1'b1);
    step("halt", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    chk("halted_o", halted, 1);
    for (int i = 0; i < 3; i++) step("halted_ign", 1'b0, 5'h1f, 5'h1f, 1'b0, 1'b0);
    chk("halted_hold", halted, 1);
    step("post_halt", 1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    chk("ph_err", err, 1);
    chk("ph_code", err_code, 3);
    chk("ph_stage", err_stage, 7);
    chk("ph_ret", retire_cnt, 5);
    chk("ph_halted", halted, 0);

    // One-cycle reset from FAULT, then normal operation.
    do_reset(1);
    chk("fr_err", err, 0);
    chk("fr_code", err_code, 0);
    chk("fr_stage", err_stage, 7);
    chk("fr_ret", retire_cnt, 0);
    run("resume", 5, 1'b1);
    chk("resume_ret", retire_cnt, 5);

    // Watchdog is disabled while halted.
    do_reset(1);
    step("halt2", 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
    run("halt_idle", 20, 1'b0);
    chk("halt_wd_err", err, 0);
    chk("halt_wd_h", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
